// File: rtl/word_entry_if.sv
// Bundles the word_entry control and result signals. The slave side is the
// word_entry block; the master side is whatever drives start/buttons/letter
// and consumes the finished word.
interface word_entry_if #(
  parameter int MAX_LEN = 8
);
  logic                   start;
  logic [4:0]             letter;
  logic                   commit_btn;
  logic                   delete_btn;
  logic                   rot_enable;
  logic                   rot_reload;
  logic [4:0]             rot_reload_val;
  logic [5*MAX_LEN-1:0]   word;
  logic [3:0]             length;
  logic                   busy;
  logic                   done;

  modport master (
    output start, letter, commit_btn, delete_btn,
    input  rot_enable, rot_reload, rot_reload_val, word, length, busy, done
  );

  modport slave (
    input  start, letter, commit_btn, delete_btn,
    output rot_enable, rot_reload, rot_reload_val, word, length, busy, done
  );
endinterface

// File: rtl/word_entry.sv
// word_entry: collects up to MAX_LEN letters from the rotary selector using
// debounced commit/delete pushbuttons, reloads the selector for each new
// character position, and emits the finished word with a one-cycle done.
module word_entry #(
  parameter int MAX_LEN         = 8,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic        clock,
  input  logic        reset,
  word_entry_if.slave bus
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]    END_CODE = 5'd26;
  localparam logic [4:0]    LAST_LTR = 5'd25;
  localparam logic [3:0]    LEN_MAX  = 4'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE,
    ENTER,
    DONE
  } state_t;

  // ---------------------------------------------------------------------
  // Button conditioning: bit 0 = commit, bit 1 = delete
  // ---------------------------------------------------------------------
  logic [1:0] raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] level;
  logic [1:0] level_d;
  logic [1:0] pulse;
  logic       commit_p;
  logic       delete_p;

  assign raw      = {bus.delete_btn, bus.commit_btn};
  assign commit_p = pulse[0];
  assign delete_p = pulse[1];

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic [CW-1:0] cnt;

    // Synchronize, require DEBOUNCE_CYCLES consecutive differing samples
    // before accepting a new level, then register a rising-edge pulse.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sync1[g]   <= 1'b0;
        sync2[g]   <= 1'b0;
        level[g]   <= 1'b0;
        level_d[g] <= 1'b0;
        pulse[g]   <= 1'b0;
        cnt        <= '0;
      end else begin
        sync1[g]   <= raw[g];
        sync2[g]   <= sync1[g];
        level_d[g] <= level[g];
        pulse[g]   <= level[g] & ~level_d[g];
        if (sync2[g] == level[g]) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt      <= '0;
          level[g] <= sync2[g];
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Entry FSM and output registers
  // ---------------------------------------------------------------------
  state_t               state;
  state_t               state_n;
  logic [5*MAX_LEN-1:0] word_q;
  logic [5*MAX_LEN-1:0] word_n;
  logic [3:0]           len_q;
  logic [3:0]           len_n;
  logic [3:0]           last_idx;
  logic [4:0]           removed;
  logic                 reload_q;
  logic                 reload_n;
  logic [4:0]           reload_val_q;
  logic [4:0]           reload_val_n;
  logic                 busy_q;
  logic                 done_q;

  // Next-state, word/length updates and selector reload requests.
  always_comb begin
    state_n      = state;
    word_n       = word_q;
    len_n        = len_q;
    reload_n     = 1'b0;
    reload_val_n = reload_val_q;
    last_idx     = len_q - 4'd1;
    removed      = END_CODE;

    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (32'(last_idx) == i) begin
        removed = word_q[5*i +: 5];
      end
    end

    case (state)
      IDLE: begin
        if (bus.start) begin
          for (int unsigned i = 0; i < MAX_LEN; i++) begin
            word_n[5*i +: 5] = END_CODE;
          end
          len_n        = '0;
          state_n      = ENTER;
          reload_n     = 1'b1;
          reload_val_n = '0;
        end
      end

      ENTER: begin
        if (commit_p && !delete_p) begin
          if (bus.letter <= LAST_LTR) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
              if (32'(len_q) == i) begin
                word_n[5*i +: 5] = bus.letter;
              end
            end
            len_n = len_q + 4'd1;
            if (len_q + 4'd1 == LEN_MAX) begin
              state_n = DONE;
            end else begin
              reload_n     = 1'b1;
              reload_val_n = '0;
            end
          end else if (bus.letter == END_CODE && len_q != '0) begin
            state_n = DONE;
          end
        end else if (delete_p && !commit_p && len_q != '0) begin
          for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (32'(last_idx) == i) begin
              word_n[5*i +: 5] = END_CODE;
            end
          end
          len_n        = last_idx;
          reload_n     = 1'b1;
          reload_val_n = removed;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and registered outputs; busy/done are decoded from the next state
  // so they line up with the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      word_q       <= {MAX_LEN{END_CODE}};
      len_q        <= '0;
      reload_q     <= 1'b0;
      reload_val_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_n;
      word_q       <= word_n;
      len_q        <= len_n;
      reload_q     <= reload_n;
      reload_val_q <= reload_val_n;
      busy_q       <= (state_n == ENTER);
      done_q       <= (state_n == DONE);
    end
  end

  assign bus.rot_enable     = busy_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.rot_reload     = reload_q;
  assign bus.rot_reload_val = reload_val_q;
  assign bus.word           = word_q;
  assign bus.length         = len_q;

endmodule

// File: tb/tb_word_entry.sv
// Bench for word_entry with MAX_LEN = 4 and DEBOUNCE_CYCLES = 4. A queue-based
// model of the word is compared with the DUT every cycle; directed scenarios
// add literal expectations.
module tb_word_entry;

  localparam int MAXL = 4;
  localparam int DB   = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  word_entry_if #(.MAX_LEN(MAXL)) bus ();

  word_entry #(
    .MAX_LEN(MAXL),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock(clk),
    .reset(reset),
    .bus(bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit checking  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // A button press is accepted once the raw level has been seen on DB
  // consecutive edges; its effect on the outputs appears 4 edges later
  // (two synchronizer stages, edge detect, then the registered update).
  logic [4:0]  m_q[$];
  int          m_state;   // 0 idle, 1 entering, 2 done strobe
  bit          m_reload;
  logic [4:0]  m_rval;
  int unsigned cyc;
  bit          m_lvl[2];
  int          m_run[2];
  int unsigned due_c[$];
  int unsigned due_d[$];
  bit          cp, dp;
  bit          rawb[2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_state  = 0;
      m_reload = 1'b0;
      m_rval   = 5'd0;
      cyc      = 0;
      m_lvl[0] = 1'b0; m_lvl[1] = 1'b0;
      m_run[0] = 0;    m_run[1] = 0;
      due_c.delete();
      due_d.delete();
    end else begin
      cyc++;
      cp = (due_c.size() > 0 && due_c[0] == cyc);
      if (cp) void'(due_c.pop_front());
      dp = (due_d.size() > 0 && due_d[0] == cyc);
      if (dp) void'(due_d.pop_front());

      rawb[0] = bus.commit_btn;
      rawb[1] = bus.delete_btn;
      for (int b = 0; b < 2; b++) begin
        if (rawb[b] == m_lvl[b]) m_run[b] = 0;
        else begin
          m_run[b]++;
          if (m_run[b] == DB) begin
            m_lvl[b] = rawb[b];
            m_run[b] = 0;
            if (rawb[b]) begin
              if (b == 0) due_c.push_back(cyc + 4);
              else        due_d.push_back(cyc + 4);
            end
          end
        end
      end

      m_reload = 1'b0;
      case (m_state)
        0: if (bus.start) begin
             m_q.delete();
             m_state  = 1;
             m_reload = 1'b1;
             m_rval   = 5'd0;
           end
        1: if (cp && !dp) begin
             if (bus.letter <= 25) begin
               m_q.push_back(bus.letter);
               if (m_q.size() == MAXL) m_state = 2;
               else begin m_reload = 1'b1; m_rval = 5'd0; end
             end else if (bus.letter == 26 && m_q.size() > 0) begin
               m_state = 2;
             end
           end else if (dp && !cp && m_q.size() > 0) begin
             m_rval   = m_q.pop_back();
             m_reload = 1'b1;
           end
        default: m_state = 0;
      endcase
    end
  end

  function automatic logic [5*MAXL-1:0] exp_word();
    logic [5*MAXL-1:0] w;
    for (int i = 0; i < MAXL; i++) w[5*i +: 5] = (i < m_q.size()) ? m_q[i] : 5'd26;
    return w;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (checking) begin
      chk("word",           64'(bus.word),           64'(exp_word()));
      chk("length",         64'(bus.length),         64'(m_q.size()));
      chk("busy",           64'(bus.busy),           64'(m_state == 1));
      chk("rot_enable",     64'(bus.rot_enable),     64'(m_state == 1));
      chk("done",           64'(bus.done),           64'(m_state == 2));
      chk("rot_reload",     64'(bus.rot_reload),     64'(m_reload));
      chk("rot_reload_val", 64'(bus.rot_reload_val), 64'(m_rval));
    end
  end

  // Event counters for literal expectations.
  int         reload_cnt = 0;
  int         done_cnt   = 0;
  logic [3:0] len_at_done = '0;
  always @(negedge clk) begin
    if (bus.rot_reload === 1'b1) reload_cnt++;
    if (bus.done === 1'b1) begin
      done_cnt++;
      len_at_done = bus.length;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic press(input bit c, input bit d, input int hold);
    bus.commit_btn = c;
    bus.delete_btn = d;
    tick(hold);
    bus.commit_btn = 1'b0;
    bus.delete_btn = 1'b0;
    tick(DB + 10);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  int done_snap;

  initial begin
    bus.start      = 1'b0;
    bus.letter     = 5'd0;
    bus.commit_btn = 1'b0;
    bus.delete_btn = 1'b0;
    #1 reset = 1'b1;
    checking = 1'b1;
    tick(3);
    chk("rst_length", 64'(bus.length), 64'd0);
    chk("rst_busy",   64'(bus.busy),   64'd0);
    chk("rst_reload", 64'(bus.rot_reload), 64'd0);
    chk("rst_word",   64'(bus.word),   64'h D6B5A);
    reset = 1'b0;
    tick(2);

    // Reset and start
    reload_cnt = 0;
    do_start();
    chk("start_busy",   64'(bus.busy),           64'd1);
    chk("start_enable", 64'(bus.rot_enable),     64'd1);
    chk("start_reload", 64'(bus.rot_reload),     64'd1);
    chk("start_rval",   64'(bus.rot_reload_val), 64'd0);
    chk("start_word",   64'(bus.word),           64'h D6B5A);
    tick(3);
    chk("start_reload_cnt", 64'(reload_cnt), 64'd1);

    // Entry and END
    bus.letter = 5'd7;  press(1'b1, 1'b0, 8);
    bus.letter = 5'd8;  press(1'b1, 1'b0, 8);
    chk("entry_len2", 64'(bus.length), 64'd2);
    done_cnt = 0;
    bus.letter = 5'd26; press(1'b1, 1'b0, 8);
    chk("end_low",  64'(bus.word[9:0]),   64'h107);
    chk("end_high", 64'(bus.word[19:10]), 64'h35A);
    chk("end_len",  64'(bus.length),      64'd2);
    chk("end_done", 64'(done_cnt),        64'd1);
    chk("end_busy", 64'(bus.busy),        64'd0);

    // Fill to MAX_LEN
    do_start();
    for (int i = 0; i < 4; i++) begin
      bus.letter = 5'(i);
      press(1'b1, 1'b0, 8);
    end
    chk("fill_len",      64'(bus.length),  64'd4);
    chk("fill_word",     64'(bus.word),    64'h18820);
    chk("fill_done_len", 64'(len_at_done), 64'd4);
    chk("fill_done_cnt", 64'(done_cnt),    64'd2);
    bus.letter = 5'd5; press(1'b1, 1'b0, 8);
    chk("fill_extra_len",  64'(bus.length), 64'd4);
    chk("fill_extra_word", 64'(bus.word),   64'h18820);
    chk("fill_extra_done", 64'(done_cnt),   64'd2);

    // Delete
    do_start();
    bus.letter = 5'd25; press(1'b1, 1'b0, 8);
    chk("del_pre_len", 64'(bus.length),   64'd1);
    chk("del_pre_s0",  64'(bus.word[4:0]), 64'd25);
    press(1'b0, 1'b1, 8);
    chk("del_len",  64'(bus.length),         64'd0);
    chk("del_word", 64'(bus.word),           64'h D6B5A);
    chk("del_rval", 64'(bus.rot_reload_val), 64'd25);
    reload_cnt = 0;
    press(1'b0, 1'b1, 8);
    chk("del2_reload", 64'(reload_cnt), 64'd0);
    chk("del2_len",    64'(bus.length), 64'd0);

    // Bounce and hold
    bus.letter = 5'd4;
    press(1'b1, 1'b0, 3);
    chk("glitch_len", 64'(bus.length), 64'd0);
    press(1'b1, 1'b0, 100);
    chk("hold_len",  64'(bus.length), 64'd1);
    chk("hold_word", 64'(bus.word),   64'h D6B44);

    // Simultaneous commit and delete
    bus.letter = 5'd6;
    press(1'b1, 1'b1, 8);
    chk("both_len",  64'(bus.length), 64'd1);
    chk("both_word", 64'(bus.word),   64'h D6B44);

    // END at length 0
    press(1'b0, 1'b1, 8);
    done_snap = done_cnt;
    bus.letter = 5'd26;
    press(1'b1, 1'b0, 8);
    chk("end0_len",  64'(bus.length), 64'd0);
    chk("end0_busy", 64'(bus.busy),   64'd1);
    chk("end0_done", 64'(done_cnt),   64'(done_snap));

    // Reset mid-entry
    bus.letter = 5'd9;
    press(1'b1, 1'b0, 8);
    chk("mid_len", 64'(bus.length), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_len",    64'(bus.length),     64'd0);
    chk("mid_rst_busy",   64'(bus.busy),       64'd0);
    chk("mid_rst_enable", 64'(bus.rot_enable), 64'd0);
    chk("mid_rst_word",   64'(bus.word),       64'h D6B5A);
    tick(2);
    reset = 1'b0;
    tick(3);

    checking = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
